// File: rtl/spi_slave_pkg.sv
// Shared constants and command codes for the SPI byte front end and its decoder.
package spi_slave_pkg;
    localparam int SPI_BYTE_W      = 8;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [SPI_BYTE_W-1:0] {
        CMD_CONF_WR = 8'h2a,
        CMD_INFO_RD = 8'h3a,
        CMD_DATA_RD = 8'h3b
    } spi_cmd_e;

    // The last bit of a byte is the one sampled while the counter reads 7.
    function automatic logic is_last_bit(input logic [2:0] cnt);
        return cnt == 3'd7;
    endfunction
endpackage

// File: rtl/spi_slave_if.sv
// SPI pins plus the byte-level handshake towards the command decoder.
interface spi_slave_if;
    import spi_slave_pkg::*;

    logic                  spi_sclk_i;
    logic                  spi_mosi_i;
    logic                  spi_cs_n_i;
    logic                  spi_dc_i;
    logic [SPI_BYTE_W-1:0] tx_data_i;
    logic                  spi_byte_vld_o;
    logic [SPI_BYTE_W-1:0] spi_byte_data_o;
    logic                  dc_o;
    logic                  tx_load_o;
    logic                  spi_miso_o;

    modport slave (
        input  spi_sclk_i, spi_mosi_i, spi_cs_n_i, spi_dc_i, tx_data_i,
        output spi_byte_vld_o, spi_byte_data_o, dc_o, tx_load_o, spi_miso_o
    );

    modport master (
        output spi_sclk_i, spi_mosi_i, spi_cs_n_i, spi_dc_i, tx_data_i,
        input  spi_byte_vld_o, spi_byte_data_o, dc_o, tx_load_o, spi_miso_o
    );
endinterface

// File: rtl/spi_slave_sync_ff.sv
// N-stage flip-flop synchronizer for one asynchronous pin, with selectable reset level.
module sync_ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain_reg;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            chain_reg <= {STAGES{RST_VAL}};
        end else begin
            chain_reg <= {chain_reg[STAGES-2:0], d};
        end
    end

    assign q = chain_reg[STAGES-1];
endmodule

// File: rtl/spi_slave.sv
// SPI mode 0 slave: synchronizes the pins into clk_i, deserialises MOSI bytes
// into one-cycle pulses and shifts a register-read byte out on MISO.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    spi_slave_if.slave  bus
);
    localparam int PIN_SCLK = 0;
    localparam int PIN_MOSI = 1;
    localparam int PIN_CS_N = 2;
    localparam int PIN_DC   = 3;

    logic [3:0] pin_raw;
    logic [3:0] pin_sync;

    assign pin_raw = {bus.spi_dc_i, bus.spi_cs_n_i, bus.spi_mosi_i, bus.spi_sclk_i};

    // Equal depth on every pin keeps MOSI/DC aligned with the synced SCLK.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sync
            sync_ff #(
                .STAGES  (SYNC_STAGES),
                .RST_VAL (gi == PIN_CS_N)
            ) u_sync (
                .clk_i   (clk_i),
                .rst_n_i (rst_n_i),
                .d       (pin_raw[gi]),
                .q       (pin_sync[gi])
            );
        end
    endgenerate

    logic sclk_s, mosi_s, cs_n_s, dc_s;
    assign sclk_s = pin_sync[PIN_SCLK];
    assign mosi_s = pin_sync[PIN_MOSI];
    assign cs_n_s = pin_sync[PIN_CS_N];
    assign dc_s   = pin_sync[PIN_DC];

    logic                  sclk_prev_reg;
    logic                  cs_n_prev_reg;
    logic [2:0]            bit_cnt_reg,    bit_cnt_next;
    logic [SPI_BYTE_W-1:0] rx_shift_reg,   rx_shift_next;
    logic [SPI_BYTE_W-1:0] tx_shift_reg,   tx_shift_next;
    logic                  byte_done_reg,  byte_done_next;
    logic                  dc_cap_reg,     dc_cap_next;
    logic                  byte_vld_reg,   byte_vld_next;
    logic [SPI_BYTE_W-1:0] byte_data_reg,  byte_data_next;
    logic                  dc_reg,         dc_next;
    logic                  tx_load_reg,    tx_load_next;
    logic                  miso_reg,       miso_next;

    logic cs_act, rise, fall, cs_fall;
    assign cs_act  = ~cs_n_s;
    assign rise    = cs_act &  sclk_s & ~sclk_prev_reg;
    assign fall    = cs_act & ~sclk_s &  sclk_prev_reg;
    assign cs_fall = cs_n_prev_reg & ~cs_n_s;

    always_comb begin
        bit_cnt_next   = bit_cnt_reg;
        rx_shift_next  = rx_shift_reg;
        tx_shift_next  = tx_shift_reg;
        byte_done_next = 1'b0;
        dc_cap_next    = dc_cap_reg;
        byte_vld_next  = byte_done_reg;
        byte_data_next = byte_data_reg;
        dc_next        = dc_reg;
        tx_load_next   = 1'b0;
        miso_next      = cs_act & tx_shift_reg[SPI_BYTE_W-1];

        // Publish the completed byte one cycle after its last rising edge.
        if (byte_done_reg) begin
            byte_data_next = rx_shift_reg;
            dc_next        = dc_cap_reg;
        end

        if (!cs_act) begin
            bit_cnt_next  = 3'd0;
            rx_shift_next = '0;
        end else if (rise) begin
            rx_shift_next = {rx_shift_reg[SPI_BYTE_W-2:0], mosi_s};
            bit_cnt_next  = bit_cnt_reg + 3'd1;
            if (is_last_bit(bit_cnt_reg)) begin
                byte_done_next = 1'b1;
                dc_cap_next    = dc_s;
            end
        end

        if (cs_fall) begin
            tx_shift_next = bus.tx_data_i;
            tx_load_next  = 1'b1;
        end else if (fall) begin
            if (bit_cnt_reg == 3'd0) begin
                tx_shift_next = bus.tx_data_i;
                tx_load_next  = 1'b1;
            end else begin
                tx_shift_next = {tx_shift_reg[SPI_BYTE_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sclk_prev_reg <= 1'b0;
            cs_n_prev_reg <= 1'b1;
            bit_cnt_reg   <= 3'd0;
            rx_shift_reg  <= '0;
            tx_shift_reg  <= '0;
            byte_done_reg <= 1'b0;
            dc_cap_reg    <= 1'b0;
            byte_vld_reg  <= 1'b0;
            byte_data_reg <= '0;
            dc_reg        <= 1'b0;
            tx_load_reg   <= 1'b0;
            miso_reg      <= 1'b0;
        end else begin
            sclk_prev_reg <= sclk_s;
            cs_n_prev_reg <= cs_n_s;
            bit_cnt_reg   <= bit_cnt_next;
            rx_shift_reg  <= rx_shift_next;
            tx_shift_reg  <= tx_shift_next;
            byte_done_reg <= byte_done_next;
            dc_cap_reg    <= dc_cap_next;
            byte_vld_reg  <= byte_vld_next;
            byte_data_reg <= byte_data_next;
            dc_reg        <= dc_next;
            tx_load_reg   <= tx_load_next;
            miso_reg      <= miso_next;
        end
    end

    assign bus.spi_byte_vld_o  = byte_vld_reg;
    assign bus.spi_byte_data_o = byte_data_reg;
    assign bus.dc_o            = dc_reg;
    assign bus.tx_load_o       = tx_load_reg;
    assign bus.spi_miso_o      = miso_reg;
endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a scoreboard of expected {dc, byte} entries is
// filled as bytes are clocked in and drained by a monitor on each valid pulse.
module tb_spi_slave;
    import spi_slave_pkg::*;

    localparam int HALF = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spi_slave_if bus();

    spi_slave #(.SYNC_STAGES(2)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;
    int vld_cnt = 0;
    int load_cnt = 0;
    logic vld_prev = 1'b0;
    logic load_prev = 1'b0;
    logic [8:0] sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: sample away from the active edge, drain the scoreboard on each pulse.
    always @(negedge clk) begin
        if (bus.spi_byte_vld_o === 1'b1) begin
            logic [8:0] e;
            vld_cnt++;
            check("vld_width", {31'd0, vld_prev}, 32'd0);
            if (sb.size() == 0) begin
                check("vld_unexpected", {31'd0, bus.spi_byte_vld_o}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("rx_data", {24'd0, bus.spi_byte_data_o}, {24'd0, e[7:0]});
                check("rx_dc", {31'd0, bus.dc_o}, {31'd0, e[8]});
                $display("vld: data=%02h dc=%0b (expected %02h/%0b)",
                         bus.spi_byte_data_o, bus.dc_o, e[7:0], e[8]);
            end
        end
        if (bus.tx_load_o === 1'b1) begin
            load_cnt++;
            check("load_width", {31'd0, load_prev}, 32'd0);
        end
        vld_prev  <= bus.spi_byte_vld_o;
        load_prev <= bus.tx_load_o;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_vld"},  {31'd0, bus.spi_byte_vld_o}, 32'd0);
        check({tag, "_data"}, {24'd0, bus.spi_byte_data_o}, 32'd0);
        check({tag, "_dc"},   {31'd0, bus.dc_o}, 32'd0);
        check({tag, "_load"}, {31'd0, bus.tx_load_o}, 32'd0);
        check({tag, "_miso"}, {31'd0, bus.spi_miso_o}, 32'd0);
    endtask

    // One SCLK period: MOSI set in the low phase, MISO captured at the rising edge.
    task automatic sclk_cycle(input logic mosi, output logic miso);
        bus.spi_mosi_i = mosi;
        wait_clk(HALF);
        bus.spi_sclk_i = 1'b1;
        miso = bus.spi_miso_o;
        wait_clk(HALF);
        bus.spi_sclk_i = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] b, input logic dc, input logic [7:0] next_tx,
                        output logic [7:0] miso_b);
        bus.spi_dc_i = dc;
        for (int i = 7; i >= 0; i--) begin
            bus.spi_mosi_i = b[i];
            wait_clk(HALF);
            if (i == 0) sb.push_back({dc, b});
            bus.spi_sclk_i = 1'b1;
            miso_b[i] = bus.spi_miso_o;
            wait_clk(HALF);
            if (i == 0) bus.tx_data_i = next_tx;
            bus.spi_sclk_i = 1'b0;
        end
        $display("xfer: mosi=%02h dc=%0b miso=%02h", b, dc, miso_b);
    endtask

    initial begin
        logic [7:0] m;
        logic       mb;
        int         vb, lb;

        bus.spi_sclk_i = 1'b0;
        bus.spi_mosi_i = 1'b0;
        bus.spi_cs_n_i = 1'b1;
        bus.spi_dc_i   = 1'b0;
        bus.tx_data_i  = 8'h00;
        rst_n          = 1'b0;

        // Reset held while the pins toggle.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.spi_sclk_i = i[0];
            bus.spi_mosi_i = ~i[0];
            bus.spi_cs_n_i = i[1];
            bus.spi_dc_i   = i[0];
            bus.tx_data_i  = 8'hFF;
            if (i >= 4) check_reset_outputs("reset");
        end
        bus.spi_sclk_i = 1'b0;
        bus.spi_cs_n_i = 1'b1;
        bus.spi_dc_i   = 1'b0;
        bus.tx_data_i  = 8'h00;
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(6);
        check("reset_vld_cnt", vld_cnt, 0);
        check("reset_load_cnt", load_cnt, 0);

        // Single command byte.
        bus.spi_cs_n_i = 1'b0;
        wait_clk(HALF);
        check("single_cs_load", load_cnt, 1);
        xfer(CMD_CONF_WR, 1'b0, 8'h00, m);
        check("single_miso", {24'd0, m}, 32'h00);
        wait_clk(HALF);
        check("single_vld_cnt", vld_cnt, 1);
        bus.spi_cs_n_i = 1'b1;
        wait_clk(HALF);

        // Burst read with tx data updated after every byte.
        vb = vld_cnt;
        lb = load_cnt;
        bus.spi_cs_n_i = 1'b0;
        wait_clk(HALF);
        xfer(CMD_DATA_RD, 1'b0, 8'hA5, m);
        check("burst_miso0", {24'd0, m}, 32'h00);
        check("burst_vld0", vld_cnt, vb + 1);
        xfer(8'h00, 1'b1, 8'h5A, m);
        check("burst_miso1", {24'd0, m}, 32'hA5);
        xfer(8'h00, 1'b1, 8'h00, m);
        check("burst_miso2", {24'd0, m}, 32'h5A);
        wait_clk(HALF);
        bus.spi_cs_n_i = 1'b1;
        wait_clk(HALF);
        check("burst_vld_cnt", vld_cnt, vb + 3);
        check("burst_load_cnt", load_cnt, lb + 4);

        // Aborted byte followed by a clean frame.
        vb = vld_cnt;
        bus.spi_cs_n_i = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < 5; i++) sclk_cycle(1'b1, mb);
        wait_clk(HALF);
        bus.spi_cs_n_i = 1'b1;
        wait_clk(2 * HALF);
        check("abort_no_vld", vld_cnt, vb);
        bus.spi_cs_n_i = 1'b0;
        wait_clk(HALF);
        xfer(8'hFF, 1'b1, 8'h00, m);
        wait_clk(HALF);
        bus.spi_cs_n_i = 1'b1;
        wait_clk(HALF);
        check("abort_next_vld", vld_cnt, vb + 1);

        // SCLK activity with chip select inactive.
        vb = vld_cnt;
        lb = load_cnt;
        bus.tx_data_i = 8'hFF;
        for (int i = 0; i < 16; i++) begin
            sclk_cycle(i[0], mb);
            if (i % 4 == 3) check("csoff_miso", {31'd0, mb}, 32'd0);
        end
        wait_clk(HALF);
        check("csoff_miso_end", {31'd0, bus.spi_miso_o}, 32'd0);
        check("csoff_vld", vld_cnt, vb);
        check("csoff_load", load_cnt, lb);
        bus.tx_data_i = 8'h00;

        // Reset in the middle of 8'hC3, then a fresh frame.
        vb = vld_cnt;
        bus.spi_cs_n_i = 1'b0;
        wait_clk(HALF);
        sclk_cycle(1'b1, mb);
        sclk_cycle(1'b1, mb);
        sclk_cycle(1'b0, mb);
        sclk_cycle(1'b0, mb);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        bus.spi_sclk_i = 1'b1;
        wait_clk(4);
        bus.spi_sclk_i = 1'b0;
        wait_clk(4);
        check_reset_outputs("midrst_hold");
        bus.spi_cs_n_i = 1'b1;
        rst_n = 1'b1;
        wait_clk(HALF);
        bus.spi_cs_n_i = 1'b0;
        wait_clk(HALF);
        xfer(CMD_INFO_RD, 1'b0, 8'h00, m);
        wait_clk(HALF);
        bus.spi_cs_n_i = 1'b1;
        wait_clk(HALF);
        check("midrst_vld", vld_cnt, vb + 1);
        check("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
